// File: rtl/stat_bar_overlay.sv
// stat_bar_overlay
// ----------------
// On-screen status-bar generator for the game overlay. Draws NUM_BARS
// horizontal bars (health, score, energy, ...) whose displayed length slews
// toward a packed target value once per frame. Each bar also reports a
// three-level colour code for the colorizer.
//
// Optional feature: define STAT_BAR_FLASH_EN to enable the damage flash.
// A bar whose target drops blinks (4 frames off / 4 frames on) for
// FLASH_FRAMES frames. With the macro undefined the flash logic is absent.
//
// Ports:
//   clk           pixel clock
//   reset         asynchronous, active-low; clears all state and outputs
//   values        target values, bar i = values[i*VAL_W +: VAL_W]
//   pixel_row     current row from the display timing generator
//   pixel_column  current column from the display timing generator
//   bar_hit       bit i set when the pixel lies on visible bar i (registered)
//   bar_level     2-bit colour code per bar: 00 none, 01 low, 10 mid, 11 high
//                 (registered, forced to 00 when that bar's hit is 0)

module stat_bar_overlay #(
    parameter int NUM_BARS     = 2,
    parameter int VAL_W        = 8,
    parameter int COL_START    = 32,
    parameter int ROW_START    = 32,
    parameter int BAR_THICK    = 33,
    parameter int BAR_PITCH    = 48,
    parameter int SCALE_SHIFT  = 0,
    parameter int STEP         = 2,
    parameter int FLASH_FRAMES = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_BARS*VAL_W-1:0]   values,
    input  logic [10:0]                 pixel_row,
    input  logic [10:0]                 pixel_column,
    output logic [NUM_BARS-1:0]         bar_hit,
    output logic [2*NUM_BARS-1:0]       bar_level
);

    localparam int MAX_COL = COL_START + ((2 ** VAL_W - 1) << SCALE_SHIFT);
    // Clamp so the step always fits the VAL_W+1 bit slew arithmetic.
    localparam int STEP_C  = (STEP > 2 ** VAL_W) ? 2 ** VAL_W : STEP;
    localparam logic [VAL_W:0]  STEP_X = (VAL_W + 1)'(STEP_C);
    localparam logic [11:0]     COL_LO = 12'(COL_START);

    // Elaboration-time parameter sanity checks.
    if (MAX_COL > 2047) begin : g_bad_geometry
        $error("stat_bar_overlay: longest bar exceeds column 2047");
    end
    if (STEP < 1) begin : g_bad_step
        $error("stat_bar_overlay: STEP must be at least 1");
    end
    if (VAL_W < 2) begin : g_bad_width
        $error("stat_bar_overlay: VAL_W must be at least 2");
    end
    if (FLASH_FRAMES < 1) begin : g_bad_flash
        $error("stat_bar_overlay: FLASH_FRAMES must be at least 1");
    end

    // ------------------------------------------------------------------
    // Frame tick: first clock at (0,0) after any other coordinate.
    // ------------------------------------------------------------------
    logic at_origin;
    logic was_origin;
    logic frame_tick;

    assign at_origin  = (pixel_row == 11'd0) && (pixel_column == 11'd0);
    assign frame_tick = at_origin && !was_origin;

    // was_origin resets to 1 so that a reset released while the scan sits at
    // (0,0) produces no tick until the coordinates leave and come back.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            was_origin <= 1'b1;
        end else begin
            was_origin <= at_origin;
        end
    end

    // Move d toward t by at most STEP, never passing t (and so never past 0
    // or the top of the range). Done at VAL_W+1 bits so the sum cannot wrap.
    function automatic logic [VAL_W-1:0] slew(input logic [VAL_W-1:0] d,
                                              input logic [VAL_W-1:0] t);
        logic [VAL_W:0] de;
        logic [VAL_W:0] te;
        logic [VAL_W:0] diff;
        logic [VAL_W:0] res;
        de   = {1'b0, d};
        te   = {1'b0, t};
        diff = '0;
        res  = de;
        if (de < te) begin
            diff = te - de;
            res  = de + ((diff > STEP_X) ? STEP_X : diff);
        end else if (de > te) begin
            diff = de - te;
            res  = de - ((diff > STEP_X) ? STEP_X : diff);
        end
        return res[VAL_W-1:0];
    endfunction

    logic [11:0] row12;
    logic [11:0] col12;
    assign row12 = {1'b0, pixel_row};
    assign col12 = {1'b0, pixel_column};

    logic [NUM_BARS-1:0]   hit_c;
    logic [2*NUM_BARS-1:0] level_c;

    // ------------------------------------------------------------------
    // Per-bar state and geometry
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_BARS; g++) begin : g_bar
        localparam logic [11:0] ROW_LO = 12'(ROW_START + g * BAR_PITCH);
        localparam logic [11:0] ROW_HI = 12'(ROW_START + g * BAR_PITCH + BAR_THICK);

        logic [VAL_W-1:0] target;
        logic [VAL_W-1:0] disp;
        logic [11:0]      col_hi;
        logic             in_rows;
        logic             in_cols;
        logic             blank;
        logic             visible;
        logic [1:0]       lvl;

        assign target = values[g*VAL_W +: VAL_W];

        // Displayed length is a handful of flops per bar, not a RAM, so it
        // is cleared by reset like any other control state.
        // NOTE: register arrays/banks that hold architectural state get an
        // explicit reset; only true RAMs are left unreset.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                disp <= '0;
            end else if (frame_tick) begin
                disp <= slew(disp, target);
            end
        end

        // disp == 0 gives col_hi == COL_LO, an empty column range.
        assign col_hi  = COL_LO + (12'(disp) << SCALE_SHIFT);
        assign in_rows = (row12 >= ROW_LO) && (row12 < ROW_HI);
        assign in_cols = (col12 >= COL_LO) && (col12 < col_hi);

        // NOTE: assign a default first in always_comb; a path that leaves a
        // variable unassigned infers a latch.
        always_comb begin
            lvl = 2'b01;
            if (disp[VAL_W-1]) begin
                lvl = 2'b11;
            end else if (disp[VAL_W-2]) begin
                lvl = 2'b10;
            end
        end

`ifdef STAT_BAR_FLASH_EN
        localparam int FW_RAW = $clog2(FLASH_FRAMES + 1);
        // At least 3 bits so the blink phase bit [2] always exists.
        localparam int FW     = (FW_RAW < 3) ? 3 : FW_RAW;
        localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_FRAMES);

        logic [VAL_W-1:0] prev;
        logic [FW-1:0]    flash;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                prev  <= '0;
                flash <= '0;
            end else if (frame_tick) begin
                if (target < prev) begin
                    flash <= FLASH_LOAD;
                end else if (flash != '0) begin
                    flash <= flash - 1'b1;
                end
                prev <= target;
            end
        end

        // Bit 2 of the down-counter toggles every 4 frames: 4 off, 4 on.
        assign blank = (flash != '0) && flash[2];
`else
        assign blank = 1'b0;
`endif

        assign visible              = in_rows && in_cols && !blank;
        assign hit_c[g]             = visible;
        assign level_c[2*g +: 2]    = visible ? lvl : 2'b00;
    end

    // ------------------------------------------------------------------
    // Output registers: one clock after the coordinates that produced them.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bar_hit   <= '0;
            bar_level <= '0;
        end else begin
            bar_hit   <= hit_c;
            bar_level <= level_c;
        end
    end

endmodule

// File: tb/tb_stat_bar_overlay.sv
// Directed testbench for stat_bar_overlay with default parameters.
// Frame ticks are produced by stepping the coordinates off (0,0) and back,
// then single pixels are probed; expected values are hand-computed from the
// slew rule (STEP = 2), the bar geometry and the level thresholds.

module tb_stat_bar_overlay;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] values;
    logic [10:0] pixel_row;
    logic [10:0] pixel_column;
    logic [1:0]  bar_hit;
    logic [3:0]  bar_level;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stat_bar_overlay #(
        .NUM_BARS     (2),
        .VAL_W        (8),
        .COL_START    (32),
        .ROW_START    (32),
        .BAR_THICK    (33),
        .BAR_PITCH    (48),
        .SCALE_SHIFT  (0),
        .STEP         (2),
        .FLASH_FRAMES (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .values       (values),
        .pixel_row    (pixel_row),
        .pixel_column (pixel_column),
        .bar_hit      (bar_hit),
        .bar_level    (bar_level)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Level thresholds for VAL_W = 8: >=128 high, >=64 mid, else low.
    function automatic logic [1:0] lvl_of(input int d);
        if (d >= 128) return 2'b11;
        if (d >= 64)  return 2'b10;
        return 2'b01;
    endfunction

    task automatic set_px(input int r, input int c);
        @(negedge clk);
        pixel_row    = 11'(r);
        pixel_column = 11'(c);
    endtask

    task automatic do_ticks(input int n);
        repeat (n) begin
            set_px(7, 7);
            set_px(0, 0);
        end
    endtask

    // With the flash built in, let any pending flash expire (target steady,
    // so the displayed length does not move).
    task automatic idle_flash();
`ifdef STAT_BAR_FLASH_EN
        do_ticks(33);
`endif
    endtask

    task automatic probe(input string tag, input int r, input int c,
                         input logic [1:0] eh, input logic [3:0] el);
        set_px(r, c);
        @(posedge clk);
        #1;
        check({tag, "/hit"}, 32'(bar_hit), 32'(eh));
        check({tag, "/lvl"}, 32'(bar_level), 32'(el));
    endtask

    // Bar 0 length d: last lit column is 32+d-1, first dark column is 32+d.
    task automatic len0(input string tag, input int d);
        if (d > 0) probe({tag, "/in"}, 32, 32 + d - 1, 2'b01, {2'b00, lvl_of(d)});
        probe({tag, "/out"}, 32, 32 + d, 2'b00, 4'b0000);
    endtask

    logic [1:0] fl_hit;
    logic [3:0] fl_lvl;

    initial begin
        reset        = 1'b0;
        values       = {8'd0, 8'd200};
        pixel_row    = '0;
        pixel_column = '0;

        // Reset held with coordinates scanning (including the origin).
        for (int k = 0; k < 6; k++) begin
            set_px((k == 3) ? 0 : 32, (k == 3) ? 0 : 30 + k * 20);
            @(posedge clk);
            #1;
            check("rst_hit", 32'(bar_hit), 32'd0);
            check("rst_lvl", 32'(bar_level), 32'd0);
        end

        @(negedge clk);
        reset        = 1'b1;
        pixel_row    = 11'd7;
        pixel_column = 11'd7;

        // Growth from 0 at 2 per frame toward 200.
        do_ticks(1);  len0("grow1", 2);
        do_ticks(1);  len0("grow2", 4);
        do_ticks(46); len0("grow48", 96);
        do_ticks(52); len0("grow100", 200);
        do_ticks(5);  len0("hold200", 200);

        // One-clock output latency.
        set_px(31, 32);
        @(posedge clk); #1;
        check("lat_before", 32'(bar_hit), 32'd0);
        set_px(32, 32);
        #1;
        check("lat_same_cycle", 32'(bar_hit), 32'd0);
        @(posedge clk); #1;
        check("lat_after", 32'(bar_hit), 32'd1);

        // Geometry with disp = 100 (200 -> 100 in 50 frames).
        values[7:0] = 8'd100;
        do_ticks(50);
        probe("geo_32_32",  32, 32,  2'b01, 4'b0010);
        probe("geo_64_131", 64, 131, 2'b01, 4'b0010);
        probe("geo_31_32",  31, 32,  2'b00, 4'b0000);
        probe("geo_65_32",  65, 32,  2'b00, 4'b0000);
        probe("geo_32_132", 32, 132, 2'b00, 4'b0000);

        // Level thresholds.
        values[7:0] = 8'd128; do_ticks(14); probe("lvl128", 32, 32, 2'b01, 4'b0011);
        values[7:0] = 8'd127; do_ticks(1);  len0("lvl127", 127);
        values[7:0] = 8'd64;  do_ticks(32); len0("lvl64", 64);
        values[7:0] = 8'd63;  do_ticks(1);  len0("lvl63", 63);

        // Slew down by less than STEP: no undershoot; then down to 0.
        values[7:0] = 8'd5; do_ticks(29); idle_flash(); len0("slew5", 5);
        values[7:0] = 8'd4; do_ticks(1);  len0("slew4", 4);
        values[7:0] = 8'd0; do_ticks(2);  len0("zero", 0);
        idle_flash();

        // Coordinates held at (0,0) for 10 clocks: exactly one update.
        values[7:0] = 8'd10;
        set_px(7, 7);
        repeat (10) set_px(0, 0);
        len0("hold_origin", 2);

        // Saturation at the top of the range with an odd remainder.
        values[7:0] = 8'd255;
        do_ticks(126); len0("sat254", 254);
        do_ticks(1);   len0("sat255", 255);
        do_ticks(3);   len0("sat_hold", 255);

        // Bar 1 geometry: rows 80..112, disp 40 -> low level.
        values[15:8] = 8'd40;
        do_ticks(20);
        probe("b1_80_32",  80,  32, 2'b10, 4'b0100);
        probe("b1_80_71",  80,  71, 2'b10, 4'b0100);
        probe("b1_80_72",  80,  72, 2'b00, 4'b0000);
        probe("b1_112_32", 112, 32, 2'b10, 4'b0100);
        probe("b1_113_32", 113, 32, 2'b00, 4'b0000);
        probe("b1_79_32",  79,  32, 2'b00, 4'b0000);

        // Damage flash: settle at 200, then drop target to 150.
        values[7:0] = 8'd200;
        do_ticks(30);
        len0("fl_settle", 200);
        values[7:0] = 8'd150;
`ifdef STAT_BAR_FLASH_EN
        fl_hit = 2'b00;
        fl_lvl = 4'b0000;
`else
        fl_hit = 2'b01;
        fl_lvl = 4'b0011;
`endif
        do_ticks(1);  probe("fl_k1_cnt32",  32, 32, 2'b01,  4'b0011);
        do_ticks(1);  probe("fl_k2_cnt31",  32, 32, fl_hit, fl_lvl);
        do_ticks(4);  probe("fl_k6_cnt27",  32, 32, 2'b01,  4'b0011);
        do_ticks(23); probe("fl_k29_cnt4",  32, 32, fl_hit, fl_lvl);
        do_ticks(4);  probe("fl_k33_cnt0",  32, 32, 2'b01,  4'b0011);
        do_ticks(7);  probe("fl_k40_idle",  32, 32, 2'b01,  4'b0011);

        // Asynchronous reset mid-line: outputs clear with no clock edge.
        probe("arst_pre", 32, 32, 2'b01, 4'b0011);
        #1;
        pixel_column = 11'd500;
        reset        = 1'b0;
        #1;
        check("arst_hit", 32'(bar_hit), 32'd0);
        check("arst_lvl", 32'(bar_level), 32'd0);

        // Release while sitting at (0,0): no tick until the scan leaves.
        set_px(0, 0);
        values[7:0] = 8'd200;
        repeat (2) set_px(0, 0);
        reset = 1'b1;
        repeat (5) set_px(0, 0);
        len0("arst_no_tick", 0);
        do_ticks(1);
        len0("arst_first_tick", 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
